// File: rtl/clock_display_pkg.sv
// Shared constants for the clock display scan path:
// FSM encoding, frame geometry and 7-segment patterns.
package clock_display_pkg;

    localparam int NUM_DIGITS     = 6;
    localparam int BITS_PER_DIGIT = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SELECT   = 3'd1;
    localparam logic [2:0] ST_LOAD     = 3'd2;
    localparam logic [2:0] ST_SHIFT_LO = 3'd3;
    localparam logic [2:0] ST_SHIFT_HI = 3'd4;
    localparam logic [2:0] ST_LATCH    = 3'd5;

    // Segment order is {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/clock_display_scanner_seg7.sv
// BCD + decimal point to 7-segment byte {dp,g,f,e,d,c,b,a}.
// Non-decimal codes blank the digit; polarity is selectable.
module seg7_decode
    import clock_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       dp_i,
    input  logic       active_low_i,
    output logic [7:0] seg_o
);

    logic [6:0] segs;

    // Digit lookup; 10..15 fall through to blank
    always_comb begin
        segs = SEG_BLANK;
        case (bcd_i)
            4'd0:    segs = SEG_0;
            4'd1:    segs = SEG_1;
            4'd2:    segs = SEG_2;
            4'd3:    segs = SEG_3;
            4'd4:    segs = SEG_4;
            4'd5:    segs = SEG_5;
            4'd6:    segs = SEG_6;
            4'd7:    segs = SEG_7;
            4'd8:    segs = SEG_8;
            4'd9:    segs = SEG_9;
            default: segs = SEG_BLANK;
        endcase
    end

    assign seg_o = active_low_i ? ~{dp_i, segs} : {dp_i, segs};

endmodule

// File: rtl/clock_display_scanner.sv
// Scans six clock digits from the BCD converter and shifts
// their segment bytes out serially, then pulses a latch.
module clock_display_scanner
    import clock_display_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic       i_frame_stb,
    output logic [3:0] o_seg_select,
    input  logic [3:0] i_bcd,
    input  logic       i_dp,
    output logic       o_sclk,
    output logic       o_sdata,
    output logic       o_latch,
    output logic       o_busy
);

    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);
    localparam logic [2:0] LAST_BIT   = 3'(BITS_PER_DIGIT - 1);

    logic [2:0] state_q, state_d;
    logic [2:0] digit_q, digit_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] sel_q, sel_d;
    logic       sclk_q, sclk_d;
    logic       sdata_q, sdata_d;
    logic       latch_q, latch_d;
    logic       busy_q, busy_d;
    logic [7:0] seg_byte;

    seg7_decode u_decode (
        .bcd_i        (i_bcd),
        .dp_i         (i_dp),
        .active_low_i (SEG_ACTIVE_LOW),
        .seg_o        (seg_byte)
    );

    // Scan sequencer: select digit, capture byte, shift 8 bits
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (i_frame_stb && i_en) begin
                    digit_d = 3'd0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: state_d = ST_LOAD;
            ST_LOAD: begin
                shift_d = seg_byte;
                bit_d   = 3'd0;
                state_d = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: state_d = ST_SHIFT_HI;
            ST_SHIFT_HI: begin
                shift_d = {shift_q[6:0], 1'b0};
                bit_d   = bit_q + 3'd1;
                if (bit_q == LAST_BIT) begin
                    if (digit_q == LAST_DIGIT) begin
                        state_d = ST_LATCH;
                    end else begin
                        digit_d = digit_q + 3'd1;
                        state_d = ST_SELECT;
                    end
                end else begin
                    state_d = ST_SHIFT_LO;
                end
            end
            ST_LATCH: begin
                digit_d = 3'd0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs computed from the next state so they leave flops
    always_comb begin
        sel_d   = (state_d == ST_IDLE) ? 4'd0 : {1'b0, digit_d};
        sclk_d  = (state_d == ST_SHIFT_HI);
        latch_d = (state_d == ST_LATCH);
        busy_d  = (state_d != ST_IDLE);
        sdata_d = 1'b0;
        if (state_d == ST_SHIFT_LO) begin
            sdata_d = shift_d[7];
        end else if (state_d == ST_SHIFT_HI) begin
            sdata_d = sdata_q;
        end
    end

    // State and output registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            digit_q <= 3'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            sel_q   <= 4'd0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sel_q   <= sel_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
        end
    end

    assign o_seg_select = sel_q;
    assign o_sclk       = sclk_q;
    assign o_sdata      = sdata_q;
    assign o_latch      = latch_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_clock_display_scanner.sv
// Directed bench: converter models feed two scanners and
// serial bytes are checked against a queued reference.
module tb_clock_display_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       stb1, stb2;
    logic [3:0] sel1, sel2;
    logic [3:0] bcd1, bcd2;
    logic       dp1, dp2;
    logic       sclk1, sclk2, sdata1, sdata2;
    logic       latch1, latch2, busy1, busy2;

    logic [3:0] tdig [6];
    logic [3:0] t2dig [6];
    logic [3:0] dp_sel;

    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clock_display_scanner #(.SEG_ACTIVE_LOW(1'b0)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_frame_stb(stb1),
        .o_seg_select(sel1), .i_bcd(bcd1), .i_dp(dp1),
        .o_sclk(sclk1), .o_sdata(sdata1), .o_latch(latch1),
        .o_busy(busy1)
    );

    clock_display_scanner #(.SEG_ACTIVE_LOW(1'b1)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_frame_stb(stb2),
        .o_seg_select(sel2), .i_bcd(bcd2), .i_dp(dp2),
        .o_sclk(sclk2), .o_sdata(sdata2), .o_latch(latch2),
        .o_busy(busy2)
    );

    // Combinational BCD converter models
    always_comb begin
        bcd1 = 4'd0;
        dp1  = 1'b0;
        if (sel1 < 4'd6) begin
            bcd1 = tdig[sel1[2:0]];
            dp1  = (sel1 == dp_sel);
        end
    end

    always_comb begin
        bcd2 = 4'd0;
        dp2  = 1'b0;
        if (sel2 < 4'd6) bcd2 = t2dig[sel2[2:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_seg(input logic [3:0] b,
                                           input logic d,
                                           input bit al);
        logic [7:0] tbl [10];
        logic [7:0] r;
        tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        r = (b < 4'd10) ? tbl[b] : 8'h00;
        r[7] = d;
        return al ? ~r : r;
    endfunction

    // Serial capture on each rising shift clock
    logic [7:0] sh1, sh2;
    int         bc1, bc2;

    always @(posedge sclk1 or posedge rst) begin
        if (rst) begin
            bc1 = 0;
        end else begin
            sh1 = {sh1[6:0], sdata1};
            bc1++;
            if (bc1 == 8) begin
                bc1 = 0;
                check("q1_has_exp", q1.size() > 0, 1);
                if (q1.size() > 0) check("byte1", sh1, q1.pop_front());
            end
        end
    end

    always @(posedge sclk2 or posedge rst) begin
        if (rst) begin
            bc2 = 0;
        end else begin
            sh2 = {sh2[6:0], sdata2};
            bc2++;
            if (bc2 == 8) begin
                bc2 = 0;
                check("q2_has_exp", q2.size() > 0, 1);
                if (q2.size() > 0) check("byte2", sh2, q2.pop_front());
            end
        end
    end

    task automatic set_time(input logic [3:0] a, b, c, d, e, f);
        tdig[0] = a; tdig[1] = b; tdig[2] = c;
        tdig[3] = d; tdig[4] = e; tdig[5] = f;
    endtask

    task automatic push_frame();
        for (int i = 0; i < 6; i++)
            q1.push_back(ref_seg(tdig[i], dp_sel == 4'(i), 1'b0));
    endtask

    // Leaves the bench at the negedge of the first SELECT cycle
    task automatic strobe();
        @(negedge clk);
        stb1 = 1'b1;
        @(negedge clk);
        stb1 = 1'b0;
    endtask

    // k counts cycles from the strobe: k=1 is the SELECT cycle
    task automatic watch(input int len, input int inj,
                         output int lcyc, output int lcnt,
                         output logic busy_lat, output logic busy_end);
        lcyc = 0;
        lcnt = 0;
        busy_lat = 1'b0;
        for (int k = 1; k <= len; k++) begin
            if (k > 1) @(negedge clk);
            if (latch1) begin
                lcnt++;
                lcyc = k;
                busy_lat = busy1;
            end
            busy_end = busy1;
            if (k == inj) begin
                stb1 = 1'b1;
                @(posedge clk);
                #1 stb1 = 1'b0;
            end
        end
    endtask

    task automatic check_frame(input string tag);
        int   lcyc, lcnt;
        logic bl, be;
        watch(115, 0, lcyc, lcnt, bl, be);
        check({tag, "_latch_cyc"}, lcyc, 109);
        check({tag, "_latch_cnt"}, lcnt, 1);
        check({tag, "_busy_lat"}, bl, 1);
        check({tag, "_busy_end"}, be, 0);
        check({tag, "_q_empty"}, q1.size(), 0);
    endtask

    initial begin
        int   lcyc, lcnt;
        logic bl, be;
        rst  = 1'b1;
        en   = 1'b1;
        stb1 = 1'b0;
        stb2 = 1'b0;
        dp_sel = 4'hF;
        set_time(4'd1, 4'd2, 4'd3, 4'd0, 4'd5, 4'd9);
        t2dig = '{4'd1, 4'hF, 4'hA, 4'd0, 4'd9, 4'd8};
        #1;
        check("rst_sel", sel1, 0);
        check("rst_sclk", sclk1, 0);
        check("rst_sdata", sdata1, 0);
        check("rst_latch", latch1, 0);
        check("rst_busy", busy1, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Full frame 12:30:59
        push_frame();
        strobe();
        check("f1_sel_first", sel1, 0);
        check("f1_busy_first", busy1, 1);
        check_frame("f1");

        // Decimal point on digit 1 only
        dp_sel = 4'd1;
        check("dp_ref", ref_seg(4'd2, 1'b1, 1'b0), 8'hDB);
        push_frame();
        strobe();
        check_frame("dp");
        dp_sel = 4'hF;

        // Strobe while busy is dropped
        push_frame();
        strobe();
        watch(115, 50, lcyc, lcnt, bl, be);
        check("ign_latch_cnt", lcnt, 1);
        check("ign_latch_cyc", lcyc, 109);
        check("ign_busy_end", be, 0);
        check("ign_q_empty", q1.size(), 0);

        // Disabled strobe never starts a frame
        en = 1'b0;
        strobe();
        for (int i = 0; i < 4; i++) begin
            check("en0_busy", busy1, 0);
            @(negedge clk);
        end
        en = 1'b1;

        // Back-to-back frames at the minimum spacing
        push_frame();
        push_frame();
        strobe();
        watch(110, 110, lcyc, lcnt, bl, be);
        check("b2b_latch_cyc", lcyc, 109);
        check("b2b_busy_110", be, 0);
        @(negedge clk);
        check("b2b_busy_next", busy1, 1);
        check_frame("b2b2");

        // Non-decimal codes blank the digit
        set_time(4'hA, 4'd5, 4'hB, 4'd9, 4'd0, 4'd7);
        check("blank_ref", ref_seg(4'hA, 1'b0, 1'b0), 8'h00);
        push_frame();
        strobe();
        check_frame("blank");

        // Active-low instance
        check("al1_ref", ref_seg(4'd1, 1'b0, 1'b1), 8'hF9);
        check("alF_ref", ref_seg(4'hF, 1'b0, 1'b1), 8'hFF);
        for (int i = 0; i < 6; i++)
            q2.push_back(ref_seg(t2dig[i], 1'b0, 1'b1));
        @(negedge clk);
        stb2 = 1'b1;
        @(negedge clk);
        stb2 = 1'b0;
        lcnt = 0;
        for (int k = 1; k <= 115; k++) begin
            if (latch2) begin
                lcnt++;
                lcyc = k;
            end
            @(negedge clk);
        end
        check("al_latch_cnt", lcnt, 1);
        check("al_latch_cyc", lcyc, 109);
        check("al_q_empty", q2.size(), 0);

        // Reset in the middle of a frame
        set_time(4'd1, 4'd2, 4'd3, 4'd0, 4'd5, 4'd9);
        push_frame();
        strobe();
        repeat (39) @(negedge clk);
        check("mid_busy_pre", busy1, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_sel", sel1, 0);
        check("mid_sclk", sclk1, 0);
        check("mid_sdata", sdata1, 0);
        check("mid_latch", latch1, 0);
        check("mid_busy", busy1, 0);
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
        lcnt = 0;
        for (int k = 0; k < 120; k++) begin
            if (latch1) lcnt++;
            @(negedge clk);
        end
        check("mid_no_latch", lcnt, 0);
        push_frame();
        strobe();
        check_frame("post_rst");

        check("end_q1", q1.size(), 0);
        check("end_q2", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_display_scanner.md
# clock_display_scanner

Sequential display-scan stage sitting directly downstream of the clock BCD converter. On each frame strobe it steps the converter's digit select through digits 0..5 and captures each returned BCD digit and decimal point. It decodes each digit to a 7-segment pattern and shifts all 48 bits serially into an external shift-register display driver, then pulses a latch. The converter itself is combinational and stays outside this block.

## Interface
- SEG_ACTIVE_LOW, 0, 1 = invert all 8 segment bits (common-anode display); 0 = active-high
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_en  in  1  enables acceptance of i_frame_stb
- i_frame_stb  in  1  single-cycle request to scan and send one frame
- o_seg_select  out  4  digit index to the BCD converter (0 = hours MSD, 5 = seconds LSD)
- i_bcd  in  4  BCD digit returned for o_seg_select (combinational, same cycle)
- i_dp  in  1  decimal point for o_seg_select
- o_sclk  out  1  serial shift clock; data is sampled downstream on its rising edge
- o_sdata  out  1  serial data, MSB first
- o_latch  out  1  one-cycle latch pulse after the last bit of a frame
- o_busy  out  1  high from the first SELECT cycle through the LATCH cycle

## Operation
- States: IDLE, SELECT, LOAD, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE
  - o_busy=0 and o_seg_select=0.
  - If i_frame_stb && i_en, set digit=0 and go to SELECT.
- SELECT (1 cycle)
  - o_seg_select=digit; lets the converter output settle.
  - Go to LOAD.
- LOAD (1 cycle)
  - shift_reg <= decode(i_bcd, i_dp); bit_cnt=0.
  - Go to SHIFT_LO.
- SHIFT_LO
  - o_sclk=0; o_sdata=shift_reg[7].
  - Go to SHIFT_HI.
- SHIFT_HI
  - o_sclk=1; o_sdata is held.
  - On exit: shift_reg <<= 1 and bit_cnt++.
  - If bit_cnt was 7: go to LATCH when digit==5; otherwise digit++ and go to SELECT.
  - Otherwise go to SHIFT_LO.
- LATCH (1 cycle): o_latch=1, then IDLE with digit=0.
- Decode to {dp,g,f,e,d,c,b,a}:
  - 0..9 map to 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - BCD 10..15 decodes to 00 (blank).
  - Bit 7 = i_dp.
  - With SEG_ACTIVE_LOW=1, the whole byte is inverted.
- Frame order on the wire: digit 0 byte first, digit 5 byte last; 48 bits total.

## Timing
- All outputs are Moore outputs driven from flops; no combinational path from inputs to o_sclk, o_sdata or o_latch.
- Reset values: o_seg_select=0, o_sclk=0, o_sdata=0, o_latch=0, o_busy=0, state=IDLE.
- Latency:
  - Strobe is sampled at edge n; SELECT occupies cycle n+1.
  - Each digit takes 18 cycles (SELECT + LOAD + 8×2 shift).
  - LATCH occupies cycle n+109; IDLE is reached at n+110.
- Minimum strobe spacing for back-to-back frames is 110 cycles. A strobe arriving in the LATCH cycle is ignored.
- i_frame_stb while o_busy=1 is ignored and not queued.
- i_en=0 blocks new frames only; a frame already in progress completes.
- i_reset asserted mid-frame:
  - All outputs go to reset values immediately, with no latch pulse.
  - The next accepted strobe sends a complete fresh frame.
- i_bcd and i_dp are sampled only in LOAD; changes at any other time have no effect on the frame.

## Structure
- Shared package clock_display_pkg holds:
  - the state encoding;
  - NUM_DIGITS=6 and BITS_PER_DIGIT=8;
  - the ten segment constants and the blank constant.
- Sub-module seg7_decode: combinational mapping (bcd, dp, active_low) -> 8-bit pattern. It is reused by any future direct-drive display path.
- Top level holds the FSM, digit counter (3 bits), bit counter (3 bits) and the 8-bit shift register.

## Test plan
- Reset: assert i_reset asynchronously mid-cycle -> all outputs 0 in the same timestep; o_busy=0.
- Full frame: bench converter model set to 12:30:59, dp=0, one strobe.
  - Captured bytes on o_sclk rising edges are 06 5B 4F 3F 6D 6F.
  - o_latch is high exactly at strobe+109 for one cycle.
- Decimal point: i_dp=1 only when o_seg_select==1 with time 12:30:59 -> second byte DB; all other bytes are unchanged.
- Strobe rules:
  - Strobe at strobe+50 -> ignored; only one latch pulse.
  - Strobe with i_en=0 -> o_busy stays 0.
  - Strobe at strobe+110 -> second full frame.
- Decode edges: BCD 0xA -> byte 00. With SEG_ACTIVE_LOW=1: BCD 1 -> F9, BCD 0xF -> FF.
- Reset mid-shift at strobe+40 -> no o_latch pulse; a new strobe yields the correct full 48-bit frame and a latch at +109.
